spi_device_core: RTL and testbench

//  SPI target (responder) for the peer end of the spi_host link: shifts a character in on sd_i

---
 rtl/spi_device_core.sv | 302 ++++++++++++++++++++++++++++++
 tb/tb_spi_device_core.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_device_core.sv
// SPI target core: oversamples the host's sclk/ss/sd pins in clk_i and shifts one character per frame.
// Register port follows tlul_adapter_reg (8-bit address, 32-bit data).
module spi_device_core #(
  parameter int MAX_LEN = 32,
  parameter int SYNC_FF = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [7:0]  addr_i,
  input  logic [31:0] wdata_i,
  input  logic [3:0]  be_i,
  input  logic        we_i,
  input  logic        re_i,
  output logic [31:0] rdata_o,
  output logic        error_o,
  output logic        intr_rx_o,
  output logic        intr_tx_o,
  input  logic        sclk_i,
  input  logic        ss_ni,
  input  logic        sd_i,
  output logic        sd_o,
  output logic        sd_oe_o
);

  localparam int LW = $clog2(MAX_LEN + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  state_e r_state;
  state_e w_state_nxt;

  logic [SYNC_FF:0]   r_sclk_sync;
  logic [SYNC_FF:0]   r_ss_sync;
  logic [SYNC_FF-1:0] r_sd_sync;

  logic         r_ctrl_en;
  logic         r_ctrl_cpol;
  logic         r_ctrl_cpha;
  logic         r_ctrl_lsb;
  logic         r_ctrl_ie_rx;
  logic         r_ctrl_ie_tx;
  logic [4:0]   r_ctrl_len;
  logic [31:0]  r_txdata;
  logic [MAX_LEN-1:0] r_rxdata;
  logic         r_rx_valid;
  logic         r_tx_empty;
  logic         r_overrun;

  logic         r_cpol;
  logic         r_cpha;
  logic         r_lsb;
  logic [LW-1:0] r_len;
  logic [LW-1:0] r_bitcnt;
  logic [MAX_LEN-1:0] r_tx_shift;
  logic [MAX_LEN-1:0] r_rx_shift;

  logic w_sclk_now;
  logic w_sclk_old;
  logic w_rise;
  logic w_fall;
  logic w_lead;
  logic w_trail;
  logic w_sample_edge;
  logic w_shift_edge;
  logic w_ss_fall;
  logic w_ss_high;
  logic w_sd;

  logic w_load;
  logic w_sample;
  logic w_shift;
  logic w_done;

  logic w_addr_ok;
  logic w_wr_ctrl;
  logic w_wr_status;
  logic w_wr_tx;
  logic w_rd_rx;
  logic w_rx_free;
  logic w_busy;

  logic [LW-1:0]      w_len_cfg;
  logic [LW-1:0]      w_tx_align;
  logic [MAX_LEN-1:0] w_tx_src;
  logic [MAX_LEN-1:0] w_tx_load;

  // Pin synchronisers; ss resets high so reset release never looks like a select.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_sclk_sync <= '0;
      r_ss_sync   <= '1;
      r_sd_sync   <= '0;
    end else begin
      r_sclk_sync <= {r_sclk_sync[SYNC_FF-1:0], sclk_i};
      r_ss_sync   <= {r_ss_sync[SYNC_FF-1:0], ss_ni};
      r_sd_sync   <= {r_sd_sync[SYNC_FF-2:0], sd_i};
    end
  end

  assign w_sclk_now    = r_sclk_sync[SYNC_FF-1];
  assign w_sclk_old    = r_sclk_sync[SYNC_FF];
  assign w_rise        = w_sclk_now & ~w_sclk_old;
  assign w_fall        = ~w_sclk_now & w_sclk_old;
  assign w_lead        = r_cpol ? w_fall : w_rise;
  assign w_trail       = r_cpol ? w_rise : w_fall;
  assign w_sample_edge = r_cpha ? w_trail : w_lead;
  assign w_shift_edge  = r_cpha ? w_lead : w_trail;
  assign w_ss_fall     = r_ss_sync[SYNC_FF] & ~r_ss_sync[SYNC_FF-1];
  assign w_ss_high     = r_ss_sync[SYNC_FF-1];
  assign w_sd          = r_sd_sync[SYNC_FF-1];

  assign w_addr_ok   = (addr_i[1:0] == 2'b00) && (addr_i[7:4] == 4'h0);
  assign w_wr_ctrl   = we_i & w_addr_ok & (addr_i[3:2] == 2'd0);
  assign w_wr_status = we_i & w_addr_ok & (addr_i[3:2] == 2'd1);
  assign w_wr_tx     = we_i & w_addr_ok & (addr_i[3:2] == 2'd2);
  assign w_rd_rx     = re_i & w_addr_ok & (addr_i[3:2] == 2'd3);
  assign w_rx_free   = ~r_rx_valid | w_rd_rx;
  assign w_busy      = (r_state != ST_IDLE);
  assign w_done      = (r_state == ST_DONE);

  // Character setup: LEN=0 (or out of range) means MAX_LEN; MSB-first data is left-aligned.
  always_comb begin
    w_len_cfg = LW'(MAX_LEN);
    if ((r_ctrl_len == 5'd0) || (int'(r_ctrl_len) > MAX_LEN)) begin
      w_len_cfg = LW'(MAX_LEN);
    end else begin
      w_len_cfg = LW'(r_ctrl_len);
    end
    w_tx_align = LW'(MAX_LEN) - w_len_cfg;
    w_tx_src   = r_tx_empty ? {MAX_LEN{1'b1}} : r_txdata[MAX_LEN-1:0];
    w_tx_load  = r_ctrl_lsb ? w_tx_src : (w_tx_src << w_tx_align);
  end

  // FSM state register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state; shifts are suppressed until the first sample so the pending edge
  // from a previous character (or the first CPHA=1 leading edge) keeps bit 0 on sd_o.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_sample    = 1'b0;
    w_shift     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_ss_fall && r_ctrl_en) begin
          w_state_nxt = ST_SHIFT;
          w_load      = 1'b1;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (w_ss_high || !r_ctrl_en) begin
          w_state_nxt = ST_IDLE;
        end else if (w_sample_edge) begin
          w_sample = 1'b1;
          if (r_bitcnt == (r_len - LW'(1))) begin
            w_state_nxt = ST_DONE;
          end else begin
            w_state_nxt = ST_SHIFT;
          end
        end else if (w_shift_edge && (r_bitcnt != '0)) begin
          w_shift = 1'b1;
        end else begin
          w_state_nxt = ST_SHIFT;
        end
      end
      ST_DONE: begin
        if (!w_ss_high && r_ctrl_en) begin
          w_state_nxt = ST_SHIFT;
          w_load      = 1'b1;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Shift datapath and per-character configuration snapshot.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_cpol     <= 1'b0;
      r_cpha     <= 1'b0;
      r_lsb      <= 1'b0;
      r_len      <= LW'(MAX_LEN);
      r_bitcnt   <= '0;
      r_tx_shift <= '0;
      r_rx_shift <= '0;
    end else if (w_load) begin
      r_cpol     <= r_ctrl_cpol;
      r_cpha     <= r_ctrl_cpha;
      r_lsb      <= r_ctrl_lsb;
      r_len      <= w_len_cfg;
      r_bitcnt   <= '0;
      r_tx_shift <= w_tx_load;
      r_rx_shift <= '0;
    end else if (w_sample) begin
      r_bitcnt <= r_bitcnt + LW'(1);
      if (r_lsb) begin
        r_rx_shift <= r_rx_shift | (MAX_LEN'(w_sd) << r_bitcnt);
      end else begin
        r_rx_shift <= {r_rx_shift[MAX_LEN-2:0], w_sd};
      end
    end else if (w_shift) begin
      if (r_lsb) begin
        r_tx_shift <= {1'b0, r_tx_shift[MAX_LEN-1:1]};
      end else begin
        r_tx_shift <= {r_tx_shift[MAX_LEN-2:0], 1'b0};
      end
    end
  end

  // Register file writes and status flags.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_ctrl_en    <= 1'b0;
      r_ctrl_cpol  <= 1'b0;
      r_ctrl_cpha  <= 1'b0;
      r_ctrl_lsb   <= 1'b0;
      r_ctrl_ie_rx <= 1'b0;
      r_ctrl_ie_tx <= 1'b0;
      r_ctrl_len   <= 5'd0;
      r_txdata     <= 32'd0;
      r_rxdata     <= '0;
      r_rx_valid   <= 1'b0;
      r_tx_empty   <= 1'b1;
      r_overrun    <= 1'b0;
    end else begin
      if (w_wr_ctrl && be_i[0]) begin
        r_ctrl_en    <= wdata_i[0];
        r_ctrl_cpol  <= wdata_i[1];
        r_ctrl_cpha  <= wdata_i[2];
        r_ctrl_lsb   <= wdata_i[3];
        r_ctrl_ie_rx <= wdata_i[4];
        r_ctrl_ie_tx <= wdata_i[5];
      end
      if (w_wr_ctrl && be_i[1]) begin
        r_ctrl_len <= wdata_i[12:8];
      end
      for (int b = 0; b < 4; b++) begin
        if (w_wr_tx && be_i[b]) begin
          r_txdata[8*b +: 8] <= wdata_i[8*b +: 8];
        end
      end
      // A host write wins over the load that consumes the previous TXDATA.
      if (w_wr_tx) begin
        r_tx_empty <= 1'b0;
      end else if (w_load) begin
        r_tx_empty <= 1'b1;
      end
      if (w_done && w_rx_free) begin
        r_rxdata   <= r_rx_shift;
        r_rx_valid <= 1'b1;
      end else if (w_rd_rx) begin
        r_rx_valid <= 1'b0;
      end
      if (w_done && !w_rx_free) begin
        r_overrun <= 1'b1;
      end else if (w_wr_status && be_i[0] && wdata_i[2]) begin
        r_overrun <= 1'b0;
      end
    end
  end

  // Read mux.
  always_comb begin
    rdata_o = 32'd0;
    if (re_i && w_addr_ok) begin
      case (addr_i[3:2])
        2'd0: rdata_o = {19'd0, r_ctrl_len, 2'b00, r_ctrl_ie_tx, r_ctrl_ie_rx,
                         r_ctrl_lsb, r_ctrl_cpha, r_ctrl_cpol, r_ctrl_en};
        2'd1: rdata_o = {28'd0, w_busy, r_overrun, r_tx_empty, r_rx_valid};
        2'd2: rdata_o = 32'd0;
        2'd3: rdata_o = 32'(r_rxdata);
        default: rdata_o = 32'd0;
      endcase
    end else begin
      rdata_o = 32'd0;
    end
  end

  assign error_o   = (we_i | re_i) & ~w_addr_ok;
  assign intr_rx_o = r_ctrl_ie_rx & r_rx_valid;
  assign intr_tx_o = r_ctrl_ie_tx & r_tx_empty;
  assign sd_oe_o   = w_busy;
  assign sd_o      = w_busy & (r_lsb ? r_tx_shift[0] : r_tx_shift[MAX_LEN-1]);

endmodule

// File: tb/tb_spi_device_core.sv
// Bench for spi_device_core: a bit-level SPI host plus a word-level model of what each side should receive.
module tb_spi_device_core;

  localparam int HALF = 8;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic [7:0]  addr_i = 8'h00;
  logic [31:0] wdata_i = 32'h0;
  logic [3:0]  be_i = 4'h0;
  logic        we_i = 1'b0;
  logic        re_i = 1'b0;
  logic [31:0] rdata_o;
  logic        error_o;
  logic        intr_rx_o;
  logic        intr_tx_o;
  logic        sclk_i = 1'b0;
  logic        ss_ni = 1'b1;
  logic        sd_i = 1'b0;
  logic        sd_o;
  logic        sd_oe_o;

  int n_checks = 0;
  int n_fail   = 0;

  spi_device_core dut (
    .clk_i(clk_i), .rst_i(rst_i), .addr_i(addr_i), .wdata_i(wdata_i), .be_i(be_i),
    .we_i(we_i), .re_i(re_i), .rdata_o(rdata_o), .error_o(error_o),
    .intr_rx_o(intr_rx_o), .intr_tx_o(intr_tx_o), .sclk_i(sclk_i), .ss_ni(ss_ni),
    .sd_i(sd_i), .sd_o(sd_o), .sd_oe_o(sd_oe_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    bit          cpol;
    bit          cpha;
    bit          lsb;
    logic [4:0]  len;
    logic [31:0] tx;
    logic [31:0] host;
    logic [31:0] exp_miso;
    logic [31:0] exp_rx;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Wire order of a character: bit k on the wire is w[k] (LSB-first) or w[n-1-k] (MSB-first).
  function automatic logic [63:0] to_bits(input logic [31:0] w, input int n, input bit lsb);
    logic [63:0] b;
    b = '0;
    for (int k = 0; k < n; k++) b[k] = lsb ? w[k] : w[n-1-k];
    return b;
  endfunction

  function automatic logic [31:0] from_bits(input logic [63:0] b, input int n, input bit lsb);
    logic [31:0] w;
    w = '0;
    for (int k = 0; k < n; k++) begin
      if (lsb) w[k] = b[k];
      else     w[n-1-k] = b[k];
    end
    return w;
  endfunction

  task automatic bus_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] be,
                           output logic err);
    @(negedge clk_i);
    addr_i = a; wdata_i = d; be_i = be; we_i = 1'b1;
    #2 err = error_o;
    @(negedge clk_i);
    we_i = 1'b0; be_i = 4'h0;
  endtask

  task automatic bus_read(input logic [7:0] a, output logic [31:0] d, output logic err);
    @(negedge clk_i);
    addr_i = a; re_i = 1'b1;
    #2 d = rdata_o; err = error_o;
    @(negedge clk_i);
    re_i = 1'b0;
  endtask

  // SPI host: one select window carrying nbits; miso[k] is what the host samples for bit k.
  task automatic spi_bits(input bit cpol, input bit cpha, input int nbits,
                          input logic [63:0] mosi, output logic [63:0] miso, output bit oe_seen);
    miso = '0;
    oe_seen = 1'b0;
    @(negedge clk_i);
    sclk_i = cpol;
    repeat (HALF) @(negedge clk_i);
    ss_ni = 1'b0;
    if (!cpha) sd_i = mosi[0];
    repeat (HALF) @(negedge clk_i);
    for (int k = 0; k < nbits; k++) begin
      if (cpha) begin
        sclk_i = ~cpol;
        sd_i = mosi[k];
        repeat (HALF) @(negedge clk_i);
        miso[k] = sd_o;
        oe_seen = oe_seen | sd_oe_o;
        sclk_i = cpol;
        repeat (HALF) @(negedge clk_i);
      end else begin
        miso[k] = sd_o;
        oe_seen = oe_seen | sd_oe_o;
        sclk_i = ~cpol;
        repeat (HALF) @(negedge clk_i);
        sclk_i = cpol;
        if (k + 1 < nbits) sd_i = mosi[k+1];
        repeat (HALF) @(negedge clk_i);
      end
    end
    ss_ni = 1'b1;
    sd_i = 1'b0;
    repeat (2 * HALF) @(negedge clk_i);
  endtask

  task automatic run_char(input bit cpol, input bit cpha, input bit lsb, input logic [4:0] len,
                          input logic [31:0] tx, input logic [31:0] host,
                          input logic [31:0] exp_miso, input logic [31:0] exp_rx, input string tag);
    int n;
    logic [63:0] mb;
    logic [31:0] rd;
    logic err;
    bit oe;
    n = (len == 5'd0) ? 32 : int'(len);
    bus_write(8'h00, {19'd0, len, 2'b00, 1'b0, 1'b1, lsb, cpha, cpol, 1'b1}, 4'hF, err);
    bus_write(8'h08, tx, 4'hF, err);
    spi_bits(cpol, cpha, n, to_bits(host, n, lsb), mb, oe);
    check({tag, " miso"}, from_bits(mb, n, lsb), exp_miso);
    check({tag, " sd_oe"}, 32'(oe), 32'd1);
    bus_read(8'h04, rd, err);
    check({tag, " status"}, rd, 32'h3);
    check({tag, " intr_rx"}, 32'(intr_rx_o), 32'd1);
    bus_read(8'h0C, rd, err);
    check({tag, " rxdata"}, rd, exp_rx);
    bus_read(8'h04, rd, err);
    check({tag, " status after read"}, rd, 32'h2);
  endtask

  initial begin
    logic [31:0] rd;
    logic [63:0] mb;
    logic [63:0] m;
    logic err;
    bit oe;

    vecs[0]  = '{1'b0, 1'b0, 1'b0, 5'd8,  32'h0000_00A5, 32'h0000_003C, 32'h0000_00A5, 32'h0000_003C};
    vecs[1]  = '{1'b0, 1'b0, 1'b0, 5'd16, 32'h0000_1234, 32'h0000_1234, 32'h0000_1234, 32'h0000_1234};
    vecs[2]  = '{1'b0, 1'b1, 1'b0, 5'd16, 32'h0000_1234, 32'h0000_1234, 32'h0000_1234, 32'h0000_1234};
    vecs[3]  = '{1'b1, 1'b0, 1'b0, 5'd16, 32'h0000_1234, 32'h0000_1234, 32'h0000_1234, 32'h0000_1234};
    vecs[4]  = '{1'b1, 1'b1, 1'b0, 5'd16, 32'h0000_1234, 32'h0000_1234, 32'h0000_1234, 32'h0000_1234};
    vecs[5]  = '{1'b0, 1'b0, 1'b1, 5'd16, 32'h0000_1234, 32'h0000_C3A5, 32'h0000_1234, 32'h0000_C3A5};
    vecs[6]  = '{1'b0, 1'b1, 1'b1, 5'd16, 32'h0000_1234, 32'h0000_C3A5, 32'h0000_1234, 32'h0000_C3A5};
    vecs[7]  = '{1'b1, 1'b0, 1'b1, 5'd16, 32'h0000_1234, 32'h0000_C3A5, 32'h0000_1234, 32'h0000_C3A5};
    vecs[8]  = '{1'b1, 1'b1, 1'b1, 5'd16, 32'h0000_1234, 32'h0000_C3A5, 32'h0000_1234, 32'h0000_C3A5};
    vecs[9]  = '{1'b0, 1'b1, 1'b0, 5'd0,  32'hDEAD_BEEF, 32'h0F1E_2D3C, 32'hDEAD_BEEF, 32'h0F1E_2D3C};
    vecs[10] = '{1'b1, 1'b0, 1'b1, 5'd5,  32'hFFFF_FFF3, 32'h0000_FF6A, 32'h0000_0013, 32'h0000_000A};

    repeat (3) @(negedge clk_i);
    rst_i = 1'b0;

    // Reset state.
    check("reset sd_oe", 32'(sd_oe_o), 32'd0);
    check("reset sd_o", 32'(sd_o), 32'd0);
    check("reset intr", {30'd0, intr_tx_o, intr_rx_o}, 32'd0);
    bus_read(8'h00, rd, err);
    check("reset ctrl", rd, 32'h0);
    check("reset error_o", 32'(err), 32'd0);
    bus_read(8'h04, rd, err);
    check("reset status", rd, 32'h2);
    bus_read(8'h0C, rd, err);
    check("reset rxdata", rd, 32'h0);

    for (int i = 0; i < 11; i++) begin
      run_char(vecs[i].cpol, vecs[i].cpha, vecs[i].lsb, vecs[i].len, vecs[i].tx, vecs[i].host,
               vecs[i].exp_miso, vecs[i].exp_rx, $sformatf("vec%0d", i));
    end

    // Random characters against the word-level model.
    for (int i = 0; i < 16; i++) begin
      bit cp, ch, lb;
      logic [4:0] ln;
      logic [31:0] tx, host;
      int n;
      cp = 1'($urandom_range(0, 1));
      ch = 1'($urandom_range(0, 1));
      lb = 1'($urandom_range(0, 1));
      ln = 5'($urandom_range(0, 31));
      tx = $urandom;
      host = $urandom;
      n = (ln == 5'd0) ? 32 : int'(ln);
      m = (64'd1 << n) - 64'd1;
      run_char(cp, ch, lb, ln, tx, host, tx & m[31:0], host & m[31:0], $sformatf("rnd%0d", i));
    end

    // Back-to-back characters without reading RXDATA: second is dropped, TX underflows to ones.
    bus_write(8'h00, 32'h0000_0801, 4'hF, err);
    bus_write(8'h08, 32'h0000_00A5, 4'hF, err);
    spi_bits(1'b0, 1'b0, 16, to_bits(32'h11, 8, 1'b0) | (to_bits(32'h22, 8, 1'b0) << 8), mb, oe);
    check("b2b miso char0", from_bits(mb, 8, 1'b0), 32'hA5);
    check("b2b miso char1", from_bits(mb >> 8, 8, 1'b0), 32'hFF);
    check("b2b intr_rx masked", 32'(intr_rx_o), 32'd0);
    bus_read(8'h04, rd, err);
    check("overrun status", rd, 32'h7);
    bus_write(8'h04, 32'h0000_0004, 4'hF, err);
    bus_read(8'h04, rd, err);
    check("overrun w1c", rd, 32'h3);
    bus_read(8'h0C, rd, err);
    check("overrun rxdata kept", rd, 32'h11);
    bus_read(8'h04, rd, err);
    check("status after rx read", rd, 32'h2);

    // Empty TX and a 3-bit abort.
    spi_bits(1'b0, 1'b0, 3, to_bits(32'h5, 3, 1'b0), mb, oe);
    check("abort miso ones", from_bits(mb, 3, 1'b0), 32'h7);
    bus_read(8'h04, rd, err);
    check("abort status", rd, 32'h2);
    bus_read(8'h0C, rd, err);
    check("abort rxdata", rd, 32'h11);

    // Illegal accesses leave everything alone.
    bus_write(8'h10, 32'hFFFF_FFFF, 4'hF, err);
    check("err write 0x10", 32'(err), 32'd1);
    bus_write(8'h05, 32'hFFFF_FFFF, 4'hF, err);
    check("err write 0x05", 32'(err), 32'd1);
    bus_read(8'h10, rd, err);
    check("err read 0x10", 32'(err), 32'd1);
    check("err read data", rd, 32'h0);
    bus_read(8'h00, rd, err);
    check("ctrl after bad writes", rd, 32'h0000_0801);
    bus_read(8'h04, rd, err);
    check("status after bad writes", rd, 32'h2);
    bus_read(8'h08, rd, err);
    check("txdata reads zero", rd, 32'h0);
    check("txdata read no error", 32'(err), 32'd0);

    // TX interrupt follows TX_EMPTY.
    bus_write(8'h00, 32'h0000_0020, 4'hF, err);
    check("intr_tx empty", 32'(intr_tx_o), 32'd1);
    bus_write(8'h08, 32'h0000_0055, 4'hF, err);
    check("intr_tx loaded", 32'(intr_tx_o), 32'd0);

    // Reset in the middle of a character.
    bus_write(8'h00, 32'h0000_0801, 4'hF, err);
    @(negedge clk_i);
    sclk_i = 1'b0;
    repeat (HALF) @(negedge clk_i);
    ss_ni = 1'b0;
    repeat (HALF) @(negedge clk_i);
    sclk_i = 1'b1;
    repeat (HALF) @(negedge clk_i);
    sclk_i = 1'b0;
    repeat (HALF) @(negedge clk_i);
    bus_read(8'h04, rd, err);
    check("midchar busy", rd, 32'hA);
    check("midchar sd_oe", 32'(sd_oe_o), 32'd1);
    @(negedge clk_i);
    rst_i = 1'b1;
    @(negedge clk_i);
    rst_i = 1'b0;
    check("rst sd_oe", 32'(sd_oe_o), 32'd0);
    check("rst sd_o", 32'(sd_o), 32'd0);
    check("rst intr", {30'd0, intr_tx_o, intr_rx_o}, 32'd0);
    bus_read(8'h00, rd, err);
    check("rst ctrl", rd, 32'h0);
    bus_read(8'h04, rd, err);
    check("rst status", rd, 32'h2);
    bus_read(8'h0C, rd, err);
    check("rst rxdata", rd, 32'h0);
    ss_ni = 1'b1;
    repeat (4) @(negedge clk_i);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
